program_loader: RTL and testbench

Boot-time instruction loader sitting directly upstream of the 24-bit single-cycle CPU's instruction memory. It receives a byte stream over a valid/ready handshake and assembles big-endian 24-bit instruction words. It writes them into instruction memory at consecutive addresses from 0 and holds the CPU stalled until a complete, checksum-verified program is resident.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader.sv | 99 +++++++++
 tb/tb_program_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared CPU definitions: instruction width, default imem depth and the boot
// loader state encoding.
package program_loader_pkg;

  localparam int WORD_W     = 24;
  localparam int ADDR_W_DEF = 8;

  typedef logic [2:0] ld_state_t;

  localparam ld_state_t S_WAIT_HDR = 3'd0;
  localparam ld_state_t S_B0       = 3'd1;
  localparam ld_state_t S_B1       = 3'd2;
  localparam ld_state_t S_B2       = 3'd3;
  localparam ld_state_t S_WRITE    = 3'd4;
  localparam ld_state_t S_CHK      = 3'd5;
  localparam ld_state_t S_DONE     = 3'd6;
  localparam ld_state_t S_ERR      = 3'd7;

  // States in which the loader can take a byte from the stream.
  function automatic logic st_ready(input ld_state_t s);
    return (s != S_WRITE) && (s != S_DONE);
  endfunction

endpackage

// File: rtl/program_loader.sv
// Boot-time loader: assembles big-endian 24-bit words from a byte stream,
// writes them to instruction memory and stalls the CPU until checksum passes.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RxValid,
  input  logic [7:0]        RxData,
  output logic              RxReady,
  output logic              ImemWe,
  output logic [ADDR_W-1:0] ImemAddr,
  output logic [WORD_W-1:0] ImemWData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  // 2^ADDR_W words is a legal program, so limits and counts carry one extra bit.
  localparam logic [8:0] HDR_MAX = 9'(1 << ADDR_W);

  ld_state_t       state, nxt;
  logic [15:0]     word;
  logic [7:0]      acc;
  logic [8:0]      n;
  logic [ADDR_W:0] cnt, cnt_inc;
  logic            xfer, hdr_ok;

  assign xfer    = RxValid && RxReady;
  assign hdr_ok  = (RxData != 8'd0) && ({1'b0, RxData} <= HDR_MAX);
  assign cnt_inc = cnt + {{ADDR_W{1'b0}}, 1'b1};

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT_HDR, S_ERR: if (xfer) nxt = hdr_ok ? S_B0 : S_ERR;
      S_B0:              if (xfer) nxt = S_B1;
      S_B1:              if (xfer) nxt = S_B2;
      S_B2:              if (xfer) nxt = S_WRITE;
      S_WRITE:           nxt = (9'(cnt_inc) == n) ? S_CHK : S_B0;
      S_CHK:             if (xfer) nxt = (RxData == acc) ? S_DONE : S_ERR;
      S_DONE:            nxt = S_DONE;
      default:           nxt = S_WAIT_HDR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_WAIT_HDR;
      word      <= '0;
      acc       <= '0;
      n         <= '0;
      cnt       <= '0;
      RxReady   <= 1'b1;
      ImemWe    <= 1'b0;
      ImemAddr  <= '0;
      ImemWData <= '0;
      CpuHold   <= 1'b1;
      Done      <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state   <= nxt;
      // Outputs are decoded from the next state so they are registered yet
      // line up with the state they describe.
      RxReady <= st_ready(nxt);
      ImemWe  <= (nxt == S_WRITE);
      CpuHold <= (nxt != S_DONE);
      Done    <= (nxt == S_DONE);
      Error   <= (nxt == S_ERR);

      if (xfer) begin
        case (state)
          S_WAIT_HDR, S_ERR: begin
            if (hdr_ok) begin
              n   <= {1'b0, RxData};
              cnt <= '0;
              acc <= RxData;
            end
          end
          S_B0, S_B1: begin
            word <= {word[7:0], RxData};
            acc  <= acc ^ RxData;
          end
          S_B2: begin
            acc       <= acc ^ RxData;
            ImemWData <= {word, RxData};
            ImemAddr  <= cnt[ADDR_W-1:0];
          end
          default: ;
        endcase
      end

      if (state == S_WRITE) cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: scoreboards imem writes and accepted
// bytes for an 8-bit and a 4-bit address instance.
module tb_program_loader;
  import program_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, sel;
  logic [7:0] data;

  logic        rdy8, we8, hold8, done8, err8;
  logic [7:0]  addr8;
  logic [23:0] wd8;
  logic        rdy4, we4, hold4, done4, err4;
  logic [3:0]  addr4;
  logic [23:0] wd4;

  program_loader #(.ADDR_W(8)) dut8 (
    .Clock(clk), .Reset(rst), .RxValid(valid & ~sel), .RxData(data),
    .RxReady(rdy8), .ImemWe(we8), .ImemAddr(addr8), .ImemWData(wd8),
    .CpuHold(hold8), .Done(done8), .Error(err8)
  );

  program_loader #(.ADDR_W(4)) dut4 (
    .Clock(clk), .Reset(rst), .RxValid(valid & sel), .RxData(data),
    .RxReady(rdy4), .ImemWe(we4), .ImemAddr(addr4), .ImemWData(wd4),
    .CpuHold(hold4), .Done(done4), .Error(err4)
  );

  logic        rdy, we, hold, done, err;
  logic [7:0]  addr;
  logic [23:0] wdata;
  always_comb begin
    rdy   = sel ? rdy4  : rdy8;
    we    = sel ? we4   : we8;
    hold  = sel ? hold4 : hold8;
    done  = sel ? done4 : done8;
    err   = sel ? err4  : err8;
    addr  = sel ? {4'b0, addr4} : addr8;
    wdata = sel ? wd4   : wd8;
  end

  int vectors = 0, miscompares = 0;
  int cyc = 0, t_hdr = 0;
  logic [31:0] exp_wr[$];
  logic [7:0]  exp_by[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard: every write pulse and every accepted byte must match the head
  // of the corresponding expectation queue.
  always @(negedge clk) begin
    if (we) begin
      chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
      if (exp_wr.size() > 0) chk("imem_write", {addr, wdata}, exp_wr.pop_front());
    end
    if (valid && rdy) begin
      chk("byte_expected", 32'(exp_by.size() > 0), 32'd1);
      if (exp_by.size() > 0) chk("byte_accepted", {24'd0, data}, {24'd0, exp_by.pop_front()});
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    data = b;
    valid = 1'b1;
    exp_by.push_back(b);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (rdy) ok = 1'b1;
    end
    chk("rx_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    if (gap > 0) begin
      valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_rdy"},   32'(rdy),   32'd1);
    chk({tag, "_we"},    32'(we),    32'd0);
    chk({tag, "_addr"},  32'(addr),  32'd0);
    chk({tag, "_wdata"}, 32'(wdata), 32'd0);
    chk({tag, "_hold"},  32'(hold),  32'd1);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_err"},   32'(err),   32'd0);
  endtask

  // Word i = base + i*step; checksum is XOR of header and payload, then
  // optionally corrupted by cs_flip.
  task automatic load(input logic [7:0] n, input logic [23:0] base, input logic [23:0] step,
                      input int gap, input logic [7:0] cs_flip);
    logic [7:0]  cs;
    logic [23:0] w;
    cs = n;
    send(n, gap);
    t_hdr = cyc;
    for (int i = 0; i < int'(n); i++) begin
      w = base + 24'(i) * step;
      exp_wr.push_back({8'(i), w});
      cs = cs ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send(w[23:16], gap);
      send(w[15:8], gap);
      send(w[7:0], gap);
    end
    send(cs ^ cs_flip, 0);
    valid = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_hold"}, 32'(hold), 32'd0);
    chk({tag, "_err"},  32'(err),  32'd0);
    chk({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    chk({tag, "_by_left"}, 32'(exp_by.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; sel = 1'b0; data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // 02 123456 ABCDEF FB, continuous valid (also high through WRITE cycles)
    load(8'h02, 24'h123456, 24'h999999, 0, 8'h00);
    chk("hdr_to_chk_cycles", 32'(cyc - t_hdr), 32'd9);
    check_done("good");
    chk("good_rdy", 32'(rdy), 32'd0);
    data = 8'h55; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_done_rdy", 32'(rdy), 32'd0);
    end
    valid = 1'b0;
    chk("post_done_bytes", 32'(exp_by.size()), 32'd0);

    // Bad checksum FA, then recovery without reset
    do_reset();
    load(8'h02, 24'h123456, 24'h999999, 0, 8'h01);
    chk("badcs_err",  32'(err),  32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_hold", 32'(hold), 32'd1);
    chk("badcs_rdy",  32'(rdy),  32'd1);
    send(8'h02, 0);
    chk("recover_err_clear", 32'(err), 32'd0);
    exp_wr.push_back({8'd0, 24'h123456});
    exp_wr.push_back({8'd1, 24'hABCDEF});
    foreach (exp_wr[i]) ;
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
    send(8'hAB, 0); send(8'hCD, 0); send(8'hEF, 0);
    send(8'hFB, 0);
    valid = 1'b0;
    check_done("recover");

    // Three idle cycles between every byte
    do_reset();
    load(8'h02, 24'h123456, 24'h999999, 3, 8'h00);
    repeat (4) begin @(posedge clk); #1; end
    check_done("gaps");

    // Zero header
    do_reset();
    send(8'h00, 0);
    valid = 1'b0;
    chk("hdr0_err",  32'(err),  32'd1);
    chk("hdr0_hold", 32'(hold), 32'd1);
    chk("hdr0_we",   32'(we),   32'd0);

    // ADDR_W=4: 0x11 rejected, 0x10 fills 0..15 without wrap
    sel = 1'b1;
    do_reset();
    send(8'h11, 0);
    valid = 1'b0;
    chk("hdr11_err", 32'(err), 32'd1);
    load(8'h10, 24'h0A0B0C, 24'h010203, 0, 8'h00);
    check_done("full16");

    // Reset mid-word, then a fresh load
    sel = 1'b0;
    do_reset();
    send(8'h02, 0); send(8'h12, 0); send(8'h34, 0);
    do_reset();
    check_idle("midreset");
    load(8'h02, 24'h123456, 24'h999999, 0, 8'h00);
    check_done("after_reset");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
